// File: rtl/rv32i_pkg.sv
// Shared RV32I datapath constants and types.
//   XLEN     : register width in bits
//   NREGS    : number of architectural registers
//   ADDR_W   : register index width
//   word_t   : one XLEN-bit register word
//   reg_idx_t: one register index
//   REG_ZERO : index of the hardwired-zero register
package rv32i_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned NREGS  = 32;
  localparam int unsigned ADDR_W = 5;

  typedef logic [XLEN-1:0]   word_t;
  typedef logic [ADDR_W-1:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = '0;

endpackage

// File: rtl/reg_word.sv
// One storage word of the register file.
//   clk  : rising-edge clock
//   rst  : synchronous active-high clear
//   load : load enable, takes d at the edge
//   d    : next value
//   q    : stored value
module reg_word #(
  parameter int unsigned Width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  logic [Width-1:0] value_q;

  // Clear has priority over load so a write in the reset cycle is lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= '0;
    end else if (load) begin
      value_q <= d;
    end
  end

  assign q = value_q;

endmodule

// File: rtl/reg_file.sv
// RV32I integer register file: two write-first combinational read ports, one synchronous write
// port, and a bypass-free debug read port. x0 reads as zero and ignores writes.
//   clk, rst           : clock and synchronous active-high clear
//   rs1_addr/rs1_data  : read port 1 (bypasses a same-cycle write)
//   rs2_addr/rs2_data  : read port 2 (bypasses a same-cycle write)
//   rd_we/addr/data    : write port
//   dbg_addr/dbg_data  : stored-contents read, no bypass
module reg_file #(
  parameter int unsigned XLEN   = rv32i_pkg::XLEN,
  parameter int unsigned NREGS  = rv32i_pkg::NREGS,
  parameter int unsigned ADDR_W = rv32i_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs1_addr,
  output logic [XLEN-1:0]   rs1_data,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [XLEN-1:0]   rs2_data,
  input  logic              rd_we,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [XLEN-1:0]   rd_data,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [XLEN-1:0]   dbg_data
);

  import rv32i_pkg::*;

  logic [XLEN-1:0]  words [NREGS];
  logic [NREGS-1:1] load_en;
  logic             write_ok;

  // A write is real only when enabled, not in reset, and not aimed at x0. The same qualifier
  // gates the bypass, so reads during reset see the stored contents.
  assign write_ok = rd_we && !rst && (rd_addr != REG_ZERO);

  always_comb begin
    load_en = '0;
    for (int unsigned i = 1; i < NREGS; i++) begin
      load_en[i] = write_ok && (rd_addr == ADDR_W'(i));
    end
  end

  assign words[0] = '0;

  for (genvar g = 1; g < NREGS; g++) begin : g_word
    reg_word #(
      .Width(XLEN)
    ) u_word (
      .clk (clk),
      .rst (rst),
      .load(load_en[g]),
      .d   (rd_data),
      .q   (words[g])
    );
  end

  // write_ok already excludes x0, so the bypass never overrides the zero word.
  always_comb begin
    rs1_data = words[rs1_addr];
    if (write_ok && (rd_addr == rs1_addr)) begin
      rs1_data = rd_data;
    end
  end

  always_comb begin
    rs2_data = words[rs2_addr];
    if (write_ok && (rd_addr == rs2_addr)) begin
      rs2_data = rd_data;
    end
  end

  assign dbg_data = words[dbg_addr];

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file.
module tb_reg_file;

  logic        clk;
  logic        rst;
  logic [4:0]  rs1_addr;
  logic [31:0] rs1_data;
  logic [4:0]  rs2_addr;
  logic [31:0] rs2_data;
  logic        rd_we;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  int n_cmp = 0;
  int n_err = 0;

  reg_file u_dut (
    .clk     (clk),
    .rst     (rst),
    .rs1_addr(rs1_addr),
    .rs1_data(rs1_data),
    .rs2_addr(rs2_addr),
    .rs2_data(rs2_data),
    .rd_we   (rd_we),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .dbg_addr(dbg_addr),
    .dbg_data(dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [4:0] addr, input logic [31:0] data);
    rd_we   = 1'b1;
    rd_addr = addr;
    rd_data = data;
    tick();
    rd_we   = 1'b0;
  endtask

  task automatic peek(input logic [4:0] addr);
    rs1_addr = addr;
    rs2_addr = addr;
    dbg_addr = addr;
    #1;
  endtask

  initial begin
    logic [4:0]  idx;
    logic [31:0] exp;

    rst      = 1'b1;
    rd_we    = 1'b0;
    rd_addr  = '0;
    rd_data  = '0;
    rs1_addr = '0;
    rs2_addr = '0;
    dbg_addr = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state.
    peek(5'd5);
    check_eq("reset_dbg_x5", dbg_data, 32'h0);
    check_eq("reset_rs1_x5", rs1_data, 32'h0);

    // Preload, then reset with a write pending in the reset cycle.
    do_write(5'd5, 32'hDEADBEEF);
    peek(5'd5);
    check_eq("preload_dbg_x5", dbg_data, 32'hDEADBEEF);
    rst      = 1'b1;
    rd_we    = 1'b1;
    rd_addr  = 5'd9;
    rd_data  = 32'h11111111;
    rs1_addr = 5'd5;
    rs2_addr = 5'd9;
    #1;
    check_eq("inrst_rs1_old_x5", rs1_data, 32'hDEADBEEF);
    check_eq("inrst_rs2_nobypass", rs2_data, 32'h0);
    tick();
    rst   = 1'b0;
    rd_we = 1'b0;
    peek(5'd5);
    check_eq("postrst_dbg_x5", dbg_data, 32'h0);
    peek(5'd9);
    check_eq("postrst_dbg_x9", dbg_data, 32'h0);
    for (int i = 1; i < 32; i++) begin
      peek(5'(i));
      check_eq($sformatf("postrst_rs1_x%0d", i), rs1_data, 32'h0);
      check_eq($sformatf("postrst_rs2_x%0d", i), rs2_data, 32'h0);
    end

    // Basic write/read on consecutive edges.
    do_write(5'd1, 32'h00000001);
    do_write(5'd31, 32'hFFFFFFFF);
    rs1_addr = 5'd1;
    rs2_addr = 5'd31;
    dbg_addr = 5'd1;
    #1;
    check_eq("basic_rs1_x1", rs1_data, 32'h00000001);
    check_eq("basic_rs2_x31", rs2_data, 32'hFFFFFFFF);
    check_eq("basic_dbg_x1", dbg_data, 32'h00000001);
    dbg_addr = 5'd31;
    #1;
    check_eq("basic_dbg_x31", dbg_data, 32'hFFFFFFFF);

    // x0 hardwire.
    rd_we   = 1'b1;
    rd_addr = 5'd0;
    rd_data = 32'h12345678;
    peek(5'd0);
    check_eq("x0_during_rs1", rs1_data, 32'h0);
    check_eq("x0_during_rs2", rs2_data, 32'h0);
    tick();
    rd_we = 1'b0;
    peek(5'd0);
    check_eq("x0_after_rs1", rs1_data, 32'h0);
    check_eq("x0_after_rs2", rs2_data, 32'h0);
    check_eq("x0_after_dbg", dbg_data, 32'h0);

    // Bypass: both read ports see the in-flight value, debug sees the old one.
    do_write(5'd7, 32'hAAAA5555);
    rd_we   = 1'b1;
    rd_addr = 5'd7;
    rd_data = 32'h0F0F0F0F;
    peek(5'd7);
    check_eq("byp_rs1", rs1_data, 32'h0F0F0F0F);
    check_eq("byp_rs2", rs2_data, 32'h0F0F0F0F);
    check_eq("byp_dbg_old", dbg_data, 32'hAAAA5555);
    tick();
    rd_we = 1'b0;
    #1;
    check_eq("byp_dbg_new", dbg_data, 32'h0F0F0F0F);
    check_eq("byp_rs1_after", rs1_data, 32'h0F0F0F0F);

    // Disabled write leaves contents alone and does not bypass.
    rd_we   = 1'b0;
    rd_addr = 5'd3;
    rd_data = 32'hCAFEBABE;
    peek(5'd3);
    check_eq("nowe_rs1_during", rs1_data, 32'h0);
    tick();
    check_eq("nowe_dbg_x3", dbg_data, 32'h0);
    check_eq("nowe_rs1_x3", rs1_data, 32'h0);

    // Back-to-back writes to one index: last edge wins.
    do_write(5'd10, 32'h00000111);
    peek(5'd10);
    check_eq("b2b_first", dbg_data, 32'h00000111);
    do_write(5'd10, 32'h00000222);
    peek(5'd10);
    check_eq("b2b_last", dbg_data, 32'h00000222);

    // Full sweep: xi = ~i on the 5-bit index, zero-extended.
    for (int i = 1; i < 32; i++) begin
      idx = 5'(i);
      do_write(idx, {27'b0, ~idx});
    end
    for (int i = 0; i < 32; i++) begin
      idx = 5'(i);
      exp = (i == 0) ? 32'h0 : {27'b0, ~idx};
      peek(idx);
      check_eq($sformatf("sweep_rs1_x%0d", i), rs1_data, exp);
      check_eq($sformatf("sweep_rs2_x%0d", i), rs2_data, exp);
      check_eq($sformatf("sweep_dbg_x%0d", i), dbg_data, exp);
    end

    // Mid-sequence reset with a pending write clears everything.
    rst     = 1'b1;
    rd_we   = 1'b1;
    rd_addr = 5'd12;
    rd_data = 32'h5A5A5A5A;
    tick();
    rst   = 1'b0;
    rd_we = 1'b0;
    for (int i = 0; i < 32; i++) begin
      peek(5'(i));
      check_eq($sformatf("midrst_dbg_x%0d", i), dbg_data, 32'h0);
    end
    peek(5'd12);
    check_eq("midrst_rs1_x12", rs1_data, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/reg_file.md
# reg_file

RV32I integer register file: 32 general-purpose registers of XLEN bits each, with two combinational read ports (rs1, rs2) and one synchronous write port (rd). x0 is hardwired to zero. Reads bypass a same-cycle write to the same register, so a read returns the value being written (write-first). It is the first storage stage of the datapath: it feeds the ALU operand inputs, including the inverter and logic-gate blocks, and receives the writeback result.

## Interface
- XLEN, 32, register width in bits
- NREGS, 32, number of architectural registers (power of two)
- ADDR_W, 5, register index width, equal to log2(NREGS)

- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset; clears every register
- rs1_addr  input  ADDR_W  read port 1 index
- rs1_data  output  XLEN  read port 1 data, combinational
- rs2_addr  input  ADDR_W  read port 2 index
- rs2_data  output  XLEN  read port 2 data, combinational
- rd_we  input  1  write enable
- rd_addr  input  ADDR_W  write index
- rd_data  input  XLEN  write data
- dbg_addr  input  ADDR_W  debug/verification read index
- dbg_data  output  XLEN  debug read data, combinational, no bypass

## Operation
- Storage: NREGS words of XLEN bits. Word 0 is never written and always reads 0.
- Write: at a rising edge of clk with rd_we=1, rst=0 and rd_addr≠0, the word at rd_addr is loaded with rd_data.
  - A write with rd_addr=0 is silently discarded.
  - rd_we=0 leaves all words unchanged.
- Read, for each of rs1 and rs2:
  - addr=0 → 0.
  - Else if rd_we=1, rd_addr=addr and rst=0 → rd_data (bypass).
  - Else → the stored word.
- rs1 and rs2 may address the same register. Both then return identical data, including the bypassed value.
- dbg_data returns the stored word only, with no bypass. dbg_addr=0 → 0.
- Reset: at a rising edge with rst=1, all words become 0. Writes in that cycle are ignored, even if rd_we=1.
- While rst=1, the bypass is disabled, so reads return the stored contents. Because reset is synchronous, these are the pre-reset values until the first edge with rst asserted.

## Timing
- Read latency: 0 cycles, address-to-data combinational.
- Write latency: 1 edge. A stored value is visible on dbg_data from the cycle after the edge. It is visible on rs1/rs2 in the same cycle via the bypass.
- Back-to-back writes to the same index on consecutive cycles: each edge takes its own cycle's rd_data, and the last one wins.
- Reset value of all outputs after the first rst edge: rs1_data=rs2_data=dbg_data=0 for any address.
- Reset asserted mid-sequence: contents are cleared at that edge. Nothing from the pending write survives.
- No internal state other than the storage array. There is no FSM and no handshake. The upstream stage must hold rd_* stable around the edge.

## Structure
- Package rv32i_pkg:
  - XLEN=32, NREGS=32, ADDR_W=5.
  - typedef word_t for XLEN bits and typedef reg_idx_t for ADDR_W bits.
  - REG_ZERO=0.
- Sub-module reg_word: one XLEN-bit register with clk, rst (sync clear) and load enable. It is instantiated NREGS-1 times for indices 1..NREGS-1.
- The top level contains:
  - the write-address decoder, which produces one-hot load enables qualified by rd_we, rst and a nonzero rd_addr;
  - three read muxes;
  - the bypass compare on rs1 and rs2.

## Test plan
- Reset clear: preload x5=0xDEADBEEF, then assert rst for 1 cycle → dbg_data(x5)=0, rs1/rs2 read 0 for x1..x31. A write with rd_we=1 in the reset cycle is not stored.
- Basic write/read: write x1=0x00000001 and x31=0xFFFFFFFF on consecutive edges → rs1_addr=1 gives 0x00000001, rs2_addr=31 gives 0xFFFFFFFF, and dbg_data matches both.
- x0 hardwire: rd_we=1, rd_addr=0, rd_data=0x12345678 → rs1_data=rs2_data=0 during and after that cycle, and dbg_data(0)=0.
- Bypass: x7 holds 0xAAAA5555. In the same cycle, drive rd_we=1, rd_addr=7, rd_data=0x0F0F0F0F with rs1_addr=rs2_addr=7 → both read 0x0F0F0F0F while dbg_data(7)=0xAAAA5555. After the edge, dbg_data(7)=0x0F0F0F0F.
- No write when disabled: rd_we=0, rd_addr=3, rd_data=0xCAFEBABE → x3 is unchanged (0) and rs1_addr=3 reads 0.
- Full sweep: write each xi=~i (bitwise NOT of the index, zero-extended to XLEN) for i=1..31, then read all through rs1, rs2 and dbg → every value matches and x0=0.
